// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared widths, FSM states and term extension for the psum accumulator
package psum_pkg;
  localparam int PSUM_W = 18;
  localparam int COL_W  = 9;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} psum_state_t;

  // One bit wider than a full psum so an unsigned 18-bit term keeps a zero top bit for later replication.
  function automatic logic [PSUM_W:0] psum_extend(input logic [PSUM_W-1:0] value,
                                                   input logic is_col,
                                                   input logic is_signed);
    logic [PSUM_W:0] result;
    if (is_col)
      result = {{(PSUM_W + 1 - COL_W){is_signed & value[COL_W-1]}}, value[COL_W-1:0]};
    else
      result = {is_signed & value[PSUM_W-1], value};
    return result;
  endfunction
endpackage

// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - psum input stream and result handshake bundle
interface psum_accumulator_if #(parameter int ACC_W = 32);
  import psum_pkg::*;

  logic [PSUM_W-1:0] psum_in;
  logic              psum_valid;
  logic              psum_ready;
  logic [ACC_W-1:0]  out_acc0;
  logic [ACC_W-1:0]  out_acc1;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output psum_in, psum_valid, out_ready,
    input  psum_ready, out_acc0, out_acc1, out_valid
  );

  modport slave (
    input  psum_in, psum_valid, out_ready,
    output psum_ready, out_acc0, out_acc1, out_valid
  );
endinterface

// File: rtl/psum_accumulator_lane.sv
// rtl/psum_accumulator_lane.sv - one accumulator lane: term extension plus load/add/hold register
module psum_lane
  import psum_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PSUM_W-1:0] i_data,
  input  logic              i_is_col,
  input  logic              i_sign,
  input  logic              i_zero,
  input  logic              i_load,
  input  logic              i_add,
  output logic [ACC_W-1:0]  o_acc
);
  logic [PSUM_W:0]  w_ext;
  logic [ACC_W-1:0] w_term_raw;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] r_acc;

  assign w_ext = psum_extend(i_data, i_is_col, i_sign);

  generate
    if (ACC_W > PSUM_W + 1) begin : g_wide
      assign w_term_raw = {{(ACC_W - PSUM_W - 1){w_ext[PSUM_W]}}, w_ext};
    end else begin : g_narrow
      assign w_term_raw = w_ext[ACC_W-1:0];
    end
  endgenerate

  assign w_term = i_zero ? '0 : w_term_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_acc <= '0;
    else if (i_load)
      r_acc <= w_term;
    else if (i_add)
      r_acc <= r_acc + w_term;
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates acc_len psum terms per result in one or two lanes
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  psum_accumulator_if.slave bus,
  input  logic             sign,
  input  logic             split_column,
  input  logic [CNT_W-1:0] acc_len,
  output logic             busy
);
  psum_state_t      r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_len;
  logic             r_sign;
  logic             r_split;
  logic             r_out_valid;
  logic             r_psum_ready;
  logic             r_busy;

  logic             w_accept;
  logic             w_first;
  logic             w_sign;
  logic             w_split;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_count_nxt;
  logic [ACC_W-1:0] w_acc0;
  logic [ACC_W-1:0] w_acc1;

  assign w_accept    = bus.psum_valid && r_psum_ready;
  assign w_first     = (r_state == IDLE);
  // The first beat of a run uses the live config; later beats use the copy latched with it.
  assign w_sign      = w_first ? sign : r_sign;
  assign w_split     = w_first ? split_column : r_split;
  assign w_len       = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign w_count_nxt = r_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_len        <= '0;
      r_sign       <= 1'b0;
      r_split      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_psum_ready <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign  <= sign;
            r_split <= split_column;
            r_len   <= w_len;
            r_count <= CNT_W'(1);
            r_busy  <= 1'b1;
            if (w_len == CNT_W'(1)) begin
              r_state      <= DONE;
              r_out_valid  <= 1'b1;
              r_psum_ready <= 1'b0;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_count <= w_count_nxt;
            if (w_count_nxt == r_len) begin
              r_state      <= DONE;
              r_out_valid  <= 1'b1;
              r_psum_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state      <= IDLE;
            r_out_valid  <= 1'b0;
            r_psum_ready <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_out_valid  <= 1'b0;
          r_psum_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  psum_lane #(.ACC_W(ACC_W)) u_lane0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_data   (bus.psum_in),
    .i_is_col (w_split),
    .i_sign   (w_sign),
    .i_zero   (1'b0),
    .i_load   (w_accept && w_first),
    .i_add    (w_accept && (r_state == ACCUM)),
    .o_acc    (w_acc0)
  );

  psum_lane #(.ACC_W(ACC_W)) u_lane1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_data   ({{(PSUM_W - COL_W){1'b0}}, bus.psum_in[PSUM_W-1:COL_W]}),
    .i_is_col (1'b1),
    .i_sign   (w_sign),
    .i_zero   (!w_split),
    .i_load   (w_accept && w_first),
    .i_add    (w_accept && (r_state == ACCUM)),
    .o_acc    (w_acc1)
  );

  assign bus.psum_ready = r_psum_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_acc0   = w_acc0;
  assign bus.out_acc1   = r_split ? w_acc1 : '0;
  assign busy           = r_busy;
endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed self-checking bench with a per-cycle behavioural model
module tb_psum_accumulator;
  logic       clk;
  logic       rst_n;
  logic       sign;
  logic       split_column;
  logic [7:0] acc_len;
  logic       busy;

  int checks;
  int failures;

  psum_accumulator_if #(.ACC_W(32)) bus ();

  psum_accumulator #(.ACC_W(32), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sign         (sign),
    .split_column (split_column),
    .acc_len      (acc_len),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a result is pending after len accepted beats until out_ready takes it.
  logic        m_valid;
  logic        m_busy;
  int          m_cnt;
  int          m_len;
  logic        m_sign;
  logic        m_split;
  logic [31:0] m_sum0;
  logic [31:0] m_sum1;
  logic [31:0] m_res0;
  logic [31:0] m_res1;

  function automatic logic [31:0] term_value(input int v, input int bits, input logic sgn);
    int val;
    val = v;
    if (sgn && v >= (1 << (bits - 1)))
      val = v - (1 << bits);
    return val;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic        s;
    logic        sp;
    int          len;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] n0;
    logic [31:0] n1;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      m_len   <= 0;
      m_sign  <= 1'b0;
      m_split <= 1'b0;
      m_sum0  <= '0;
      m_sum1  <= '0;
      m_res0  <= '0;
      m_res1  <= '0;
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else if (bus.psum_valid) begin
      if (m_cnt == 0) begin
        s   = sign;
        sp  = split_column;
        len = (acc_len == 0) ? 1 : int'(acc_len);
      end else begin
        s   = m_sign;
        sp  = m_split;
        len = m_len;
      end
      if (sp) begin
        t0 = term_value(int'(bus.psum_in[8:0]), 9, s);
        t1 = term_value(int'(bus.psum_in[17:9]), 9, s);
      end else begin
        t0 = term_value(int'(bus.psum_in), 18, s);
        t1 = 32'd0;
      end
      n0 = (m_cnt == 0) ? t0 : m_sum0 + t0;
      n1 = (m_cnt == 0) ? t1 : m_sum1 + t1;
      m_sign  <= s;
      m_split <= sp;
      m_len   <= len;
      m_sum0  <= n0;
      m_sum1  <= n1;
      m_busy  <= 1'b1;
      if (m_cnt + 1 == len) begin
        m_valid <= 1'b1;
        m_res0  <= n0;
        m_res1  <= sp ? n1 : 32'd0;
        m_cnt   <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("model_psum_ready", 32'(bus.psum_ready), 32'(!m_valid));
    chk("model_busy", 32'(busy), 32'(m_busy));
    if (m_valid) begin
      chk("model_out_acc0", bus.out_acc0, m_res0);
      chk("model_out_acc1", bus.out_acc1, m_res1);
    end
  end

  task automatic beat(input logic [17:0] d);
    bus.psum_in    = d;
    bus.psum_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.psum_valid = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic config_run(input logic s, input logic sp, input logic [7:0] len);
    sign         = s;
    split_column = sp;
    acc_len      = len;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.psum_in    = '0;
    bus.psum_valid = 1'b0;
    bus.out_ready  = 1'b0;
    config_run(1'b0, 1'b0, 8'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_psum_ready", 32'(bus.psum_ready), 32'd1);
    chk("reset_acc0", bus.out_acc0, 32'd0);
    chk("reset_acc1", bus.out_acc1, 32'd0);

    config_run(1'b0, 1'b0, 8'd3);
    beat(18'h00010);
    beat(18'h00020);
    chk("u3_not_yet_valid", 32'(bus.out_valid), 32'd0);
    beat(18'h00030);
    chk("u3_valid_latency", 32'(bus.out_valid), 32'd1);
    chk("u3_acc0", bus.out_acc0, 32'h60);
    chk("u3_acc1", bus.out_acc1, 32'h0);
    take();
    chk("u3_valid_dropped", 32'(bus.out_valid), 32'd0);

    config_run(1'b1, 1'b0, 8'd2);
    beat(18'h3FFFF);
    beat(18'h3FFFE);
    chk("s2_acc0", bus.out_acc0, 32'hFFFFFFFD);
    take();

    config_run(1'b1, 1'b1, 8'd2);
    beat(18'h3FE02);
    beat(18'h3FE02);
    chk("split_s_acc0", bus.out_acc0, 32'd4);
    chk("split_s_acc1", bus.out_acc1, 32'hFFFFFFFE);
    take();
    config_run(1'b0, 1'b1, 8'd2);
    beat(18'h3FE02);
    beat(18'h3FE02);
    chk("split_u_acc0", bus.out_acc0, 32'd4);
    chk("split_u_acc1", bus.out_acc1, 32'h3FE);
    take();

    config_run(1'b0, 1'b0, 8'd1);
    beat(18'h00007);
    bus.psum_in    = 18'h00009;
    bus.psum_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
      chk("bp_acc0_stable", bus.out_acc0, 32'd7);
      chk("bp_ready_low", 32'(bus.psum_ready), 32'd0);
    end
    take();
    chk("bp_idle_ready", 32'(bus.psum_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.psum_valid = 1'b0;
    chk("bp_held_beat_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_held_beat_acc0", bus.out_acc0, 32'd9);
    take();

    config_run(1'b0, 1'b0, 8'd0);
    beat(18'h00005);
    chk("len0_valid", 32'(bus.out_valid), 32'd1);
    chk("len0_acc0", bus.out_acc0, 32'd5);
    take();

    config_run(1'b1, 1'b0, 8'd4);
    beat(18'h3FFFF);
    config_run(1'b0, 1'b1, 8'd2);
    beat(18'h3FFFF);
    chk("latch_not_done_early", 32'(bus.out_valid), 32'd0);
    beat(18'h3FFFF);
    beat(18'h00004);
    chk("latch_valid", 32'(bus.out_valid), 32'd1);
    chk("latch_acc0", bus.out_acc0, 32'd1);
    chk("latch_acc1", bus.out_acc1, 32'd0);
    take();

    config_run(1'b0, 1'b0, 8'd4);
    beat(18'h00001);
    beat(18'h00001);
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst_acc0", bus.out_acc0, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      beat(18'h00001);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_acc0", bus.out_acc0, 32'd4);
    take();
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
